// File: rtl/vend_coin_sequencer.sv
// vend_coin_sequencer: queues raw coin-sensor pulses and feeds the single-coin vending core
// one coin per transaction, then runs the soda-dispense and nickel-eject handshakes.
module vend_coin_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic             i_clk,
    input  logic             reset_n,
    input  logic             i_coin_n,
    input  logic             i_coin_d,
    input  logic             i_coin_q,
    output logic             o_nickle,
    output logic             o_dime,
    output logic             o_quarter,
    input  logic             i_soda,
    input  logic [2:0]       i_change,
    output logic             o_vend_req,
    input  logic             i_vend_ack,
    output logic             o_eject,
    input  logic             i_eject_done,
    output logic [2:0]       o_return,
    output logic             o_busy,
    output logic [PTR_W:0]   o_fifo_cnt,
    output logic [7:0]       o_sales_cnt
);
    localparam int CW = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, VEND, EJECT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       mem_q [FIFO_DEPTH];
    logic [1:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d, free, n_push;
    logic [2:0]       sens, ret_d, ret_q, coin_d, coin_q, change_d, change_q;
    logic [1:0]       head;
    logic [7:0]       sales_d, sales_q;
    logic             pop;

    // Free space is judged on start-of-cycle occupancy; a same-cycle pop frees nothing yet.
    always_comb begin
        sens   = {i_coin_q, i_coin_d, i_coin_n};
        free   = CW'(FIFO_DEPTH) - cnt_q;
        n_push = '0;
        wr_d   = wr_q;
        ret_d  = 3'b000;
        mem_d  = mem_q;
        for (int k = 0; k < 3; k++) begin
            if (sens[k]) begin
                if (n_push < free) begin
                    mem_d[wr_d] = 2'(k + 1);
                    wr_d        = wr_d + PTR_W'(1);
                    n_push      = n_push + CW'(1);
                end else begin
                    ret_d[k] = 1'b1;
                end
            end
        end
    end

    assign head  = mem_q[rd_q];
    assign cnt_d = cnt_q + n_push - CW'(pop);

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        coin_d   = 3'b000;
        change_d = change_q;
        sales_d  = sales_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    rd_d    = rd_q + PTR_W'(1);
                    coin_d  = {head == 2'b11, head == 2'b10, head == 2'b01};
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                change_d = i_soda ? i_change : change_q;
                state_d  = i_soda ? VEND : IDLE;
            end
            VEND: begin
                if (i_vend_ack) begin
                    sales_d = sales_q + 8'd1;
                    state_d = (change_q != 3'd0) ? EJECT : IDLE;
                end
            end
            EJECT: begin
                if (i_eject_done) begin
                    change_d = change_q - 3'd1;
                    state_d  = (change_q == 3'd1) ? IDLE : EJECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            ret_q    <= 3'b000;
            coin_q   <= 3'b000;
            change_q <= 3'd0;
            sales_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            ret_q    <= ret_d;
            coin_q   <= coin_d;
            change_q <= change_d;
            sales_q  <= sales_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define which entries are valid.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_nickle    = coin_q[0];
    assign o_dime      = coin_q[1];
    assign o_quarter   = coin_q[2];
    assign o_return    = ret_q;
    assign o_vend_req  = state_q == VEND;
    assign o_eject     = state_q == EJECT;
    assign o_busy      = state_q != IDLE;
    assign o_fifo_cnt  = cnt_q;
    assign o_sales_cnt = sales_q;
endmodule

// File: tb/tb_vend_coin_sequencer.sv
// tb_vend_coin_sequencer: directed vectors with hand-computed expectations for vend_coin_sequencer.
module tb_vend_coin_sequencer;
    logic       i_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_coin_n = 1'b0, i_coin_d = 1'b0, i_coin_q = 1'b0;
    logic       o_nickle, o_dime, o_quarter;
    logic       i_soda = 1'b0;
    logic [2:0] i_change = 3'd0;
    logic       o_vend_req;
    logic       i_vend_ack = 1'b0;
    logic       o_eject;
    logic       i_eject_done = 1'b0;
    logic [2:0] o_return;
    logic       o_busy;
    logic [2:0] o_fifo_cnt;
    logic [7:0] o_sales_cnt;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [2:0] issued [$];
    int         issued_at [$];

    vend_coin_sequencer dut (
        .i_clk(i_clk), .reset_n(reset_n),
        .i_coin_n(i_coin_n), .i_coin_d(i_coin_d), .i_coin_q(i_coin_q),
        .o_nickle(o_nickle), .o_dime(o_dime), .o_quarter(o_quarter),
        .i_soda(i_soda), .i_change(i_change),
        .o_vend_req(o_vend_req), .i_vend_ack(i_vend_ack),
        .o_eject(o_eject), .i_eject_done(i_eject_done),
        .o_return(o_return), .o_busy(o_busy),
        .o_fifo_cnt(o_fifo_cnt), .o_sales_cnt(o_sales_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic wait_issues(input string tag, input int n);
        int k = 0;
        while (issued.size() < n && k < 40) begin
            tick();
            k++;
        end
        chk(tag, issued.size(), n);
    endtask

    // Records every coin handed to the core, shortly after each rising edge.
    always @(posedge i_clk) begin
        cyc++;
        #2;
        if ({o_quarter, o_dime, o_nickle} != 3'b000) begin
            chk("coin_onehot", $countones({o_quarter, o_dime, o_nickle}), 1);
            issued.push_back({o_quarter, o_dime, o_nickle});
            issued_at.push_back(cyc);
        end
    end

    initial begin
        tick(); tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_cnt", o_fifo_cnt, 0);
        chk("rst_sales", o_sales_cnt, 0);
        chk("rst_outs", {o_vend_req, o_eject, o_return, o_quarter, o_dime, o_nickle}, 0);
        reset_n = 1'b1;

        // single quarter, change of one nickel
        i_coin_q = 1; tick(); i_coin_q = 0;
        chk("t1_cnt_push", o_fifo_cnt, 1);
        tick();
        chk("t1_issue_q", {o_quarter, o_dime, o_nickle}, 3'b100);
        chk("t1_cnt_pop", o_fifo_cnt, 0);
        chk("t1_busy", o_busy, 1);
        tick();
        chk("t1_coin_off", {o_quarter, o_dime, o_nickle}, 0);
        i_soda = 1; i_change = 3'd1; tick(); i_soda = 0; i_change = 0;
        chk("t1_vend", o_vend_req, 1);
        tick();
        chk("t1_vend_hold", o_vend_req, 1);
        i_vend_ack = 1; tick(); i_vend_ack = 0;
        chk("t1_vend_drop", o_vend_req, 0);
        chk("t1_eject", o_eject, 1);
        chk("t1_sales", o_sales_cnt, 1);
        i_eject_done = 1; tick(); i_eject_done = 0;
        chk("t1_eject_drop", o_eject, 0);
        chk("t1_idle", o_busy, 0);
        chk("t1_cnt_end", o_fifo_cnt, 0);

        // N, D, N in separate cycles; vend without change on the third
        issued.delete(); issued_at.delete();
        i_coin_n = 1; tick(); i_coin_n = 0;
        i_coin_d = 1; tick(); i_coin_d = 0;
        i_coin_n = 1; tick(); i_coin_n = 0;
        wait_issues("t2_issued", 3);
        tick();
        i_soda = 1; i_change = 3'd0; tick(); i_soda = 0;
        chk("t2_vend", o_vend_req, 1);
        i_vend_ack = 1; tick(); i_vend_ack = 0;
        chk("t2_no_eject", o_eject, 0);
        chk("t2_idle", o_busy, 0);
        chk("t2_sales", o_sales_cnt, 2);
        chk("t2_c0", issued[0], 3'b001);
        chk("t2_c1", issued[1], 3'b010);
        chk("t2_c2", issued[2], 3'b001);
        chk("t2_gap01", issued_at[1] - issued_at[0], 3);
        chk("t2_gap12", issued_at[2] - issued_at[1], 3);

        // simultaneous N+D+Q into an empty FIFO
        issued.delete(); issued_at.delete();
        {i_coin_q, i_coin_d, i_coin_n} = 3'b111; tick(); {i_coin_q, i_coin_d, i_coin_n} = 3'b000;
        chk("t3_cnt3", o_fifo_cnt, 3);
        chk("t3_ret", o_return, 0);
        tick();
        chk("t3_cnt2", o_fifo_cnt, 2);
        wait_issues("t3_issued", 3);
        tick(); tick();
        chk("t3_c0", issued[0], 3'b001);
        chk("t3_c1", issued[1], 3'b010);
        chk("t3_c2", issued[2], 3'b100);
        chk("t3_cnt_end", o_fifo_cnt, 0);
        chk("t3_idle", o_busy, 0);

        // 3/4 full while IDLE pops, plus N+D: dime rejected
        issued.delete(); issued_at.delete();
        {i_coin_q, i_coin_d, i_coin_n} = 3'b111; tick(); {i_coin_q, i_coin_d, i_coin_n} = 3'b000;
        {i_coin_d, i_coin_n} = 2'b11; tick(); {i_coin_d, i_coin_n} = 2'b00;
        chk("t4_ret", o_return, 3'b010);
        chk("t4_cnt", o_fifo_cnt, 3);
        tick();
        chk("t4_ret_clr", o_return, 0);
        chk("t4_cnt_hold", o_fifo_cnt, 3);
        wait_issues("t4_issued", 4);
        tick(); tick();
        chk("t4_c0", issued[0], 3'b001);
        chk("t4_c3", issued[3], 3'b001);
        chk("t4_cnt_end", o_fifo_cnt, 0);

        // quarter on balance 15: four nickels back, spurious ack ignored
        issued.delete(); issued_at.delete();
        i_coin_q = 1; tick(); i_coin_q = 0;
        wait_issues("t5_issued", 1);
        tick();
        i_soda = 1; i_change = 3'd4; tick(); i_soda = 0; i_change = 0;
        chk("t5_vend", o_vend_req, 1);
        i_vend_ack = 1; tick(); i_vend_ack = 0;
        chk("t5_eject", o_eject, 1);
        chk("t5_sales", o_sales_cnt, 3);
        i_vend_ack = 1; tick(); i_vend_ack = 0;
        chk("t5_spur_eject", o_eject, 1);
        chk("t5_spur_sales", o_sales_cnt, 3);
        chk("t5_spur_vend", o_vend_req, 0);
        for (int i = 0; i < 4; i++) begin
            i_eject_done = 1; tick(); i_eject_done = 0;
            chk($sformatf("t5_eject_%0d", i), o_eject, (i < 3) ? 1 : 0);
            if (i < 3) begin
                tick();
                chk($sformatf("t5_eject_gap_%0d", i), o_eject, 1);
            end
        end
        chk("t5_idle", o_busy, 0);

        // async reset during EJECT with 2 nickels pending and 2 coins buffered
        i_coin_q = 1; tick(); i_coin_q = 0;
        wait_issues("t6_issued", 2);
        tick();
        i_soda = 1; i_change = 3'd3; tick(); i_soda = 0; i_change = 0;
        {i_coin_d, i_coin_n} = 2'b11; tick(); {i_coin_d, i_coin_n} = 2'b00;
        i_vend_ack = 1; tick(); i_vend_ack = 0;
        i_eject_done = 1; tick(); i_eject_done = 0;
        chk("t6_eject", o_eject, 1);
        chk("t6_cnt", o_fifo_cnt, 2);
        chk("t6_sales", o_sales_cnt, 4);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_eject", o_eject, 0);
        chk("t6_rst_busy", o_busy, 0);
        chk("t6_rst_cnt", o_fifo_cnt, 0);
        chk("t6_rst_sales", o_sales_cnt, 0);
        chk("t6_rst_outs", {o_vend_req, o_return, o_quarter, o_dime, o_nickle}, 0);
        tick(); tick();
        reset_n = 1'b1;
        issued.delete(); issued_at.delete();
        repeat (5) tick();
        chk("t6_post_eject", o_eject, 0);
        chk("t6_post_busy", o_busy, 0);
        chk("t6_post_cnt", o_fifo_cnt, 0);
        chk("t6_post_issue", issued.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
